// File: rtl/iomem_ram_responder_pkg.sv
// iomem_ram_responder_pkg: shared FSM encodings and wait-counter width
package iomem_ram_responder_pkg;
  localparam int WS_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/iomem_ram_responder_if.sv
// iomem_ram_responder_if: iomem bus signals with initiator/responder views
interface iomem_ram_responder_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/iomem_ram_responder_word_ram.sv
// iomem_word_ram: word RAM with byte write enables, sync write, async read
module iomem_word_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**ADDR_W];
  assign rdata_o = mem_q[raddr_i];
  // each enabled byte lane updates independently; others keep their value
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end
endmodule

// File: rtl/iomem_ram_responder.sv
// iomem_ram_responder: iomem target serving a RAM window with wait states
module iomem_ram_responder
  import iomem_ram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  iomem_ram_responder_if.slave bus,
  output logic                 sel_o
);
  state_e            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, raddr;
  logic [3:0]        wstrb_q, wstrb_d, we;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, ram_rdata;
  logic              hit;
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^bus.iomem_addr[1:0];
  assign hit   = bus.iomem_valid && bus.iomem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign raddr = state_q == IDLE ? bus.iomem_addr[ADDR_W+1:2] : idx_q;

  iomem_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // state and transaction registers; reset drops any pending write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // next state: accept hits in IDLE, count down waits, abort if valid drops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (hit) begin
        idx_d   = bus.iomem_addr[ADDR_W+1:2];
        wstrb_d = bus.iomem_wstrb;
        wdata_d = bus.iomem_wdata;
        cnt_d   = WS_W'(WAIT_STATES);
        state_d = WAIT_STATES > 0 ? WAIT : ACK;
      end
      WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = !bus.iomem_valid ? IDLE : cnt_q == WS_W'(1) ? ACK : WAIT;
      end
      default: state_d = IDLE;
    endcase
    rdata_d = state_d == ACK && wstrb_d == 4'b0 ? ram_rdata : '0;
  end

  // outputs: zero unless acknowledging, so responders can be OR-combined
  always_comb begin
    bus.iomem_ready = state_q == ACK;
    bus.iomem_rdata = rdata_q;
    sel_o           = state_q != IDLE;
    we              = state_q == ACK ? wstrb_q : 4'b0;
  end
endmodule

// File: doc/iomem_ram_responder.md
Name: iomem_ram_responder

Overview:
- Target (responder) side of the core's iomem bus.
- Decodes a fixed address window and serves 32-bit reads and byte-strobed writes from an internal word RAM, with a programmable number of wait states.
- Sits beside other iomem peripherals at top level. Its rdata and ready are zero when it is not acknowledging, so the top can OR-combine responders.

Parameters:
- BASE_ADDR, 32'h4000_0000, window base; must be aligned to window size.
- ADDR_W, 10, word-address width; window = 2^ADDR_W words (4 KiB default).
- WAIT_STATES, 1, extra cycles between request accept and ready (0..15).

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- iomem_valid  input  1  initiator request valid
- iomem_ready  output  1  one-cycle acknowledge
- iomem_wstrb  input  4  byte write strobes; 0 = read
- iomem_addr  input  32  byte address; bits [1:0] ignored
- iomem_wdata  input  32  write data
- iomem_rdata  output  32  read data, valid only while iomem_ready=1, else 0
- sel_o  output  1  high while this block owns the current transaction (IDLE excluded)

Behaviour:
- Single clock, clk. resetn is asynchronous, active-low.
- Reset values: iomem_ready=0, iomem_rdata=0, sel_o=0, state=IDLE, wait counter=0. RAM contents are not reset.
- Hit: iomem_valid & (iomem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]). Word index = iomem_addr[ADDR_W+1:2].
- Protocol: the initiator holds valid/addr/wstrb/wdata stable until it samples ready=1. A new request may be presented in the cycle after ready.
- FSM states are IDLE, WAIT, ACK.
  - IDLE: on hit, latch the index, wstrb and wdata, and set the counter to WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACK. Misses are ignored: ready stays 0 and the state stays IDLE.
  - WAIT: decrement the counter. When it reaches 1, go to ACK. If iomem_valid drops (protocol abort), go to IDLE with no write and no ready.
  - ACK: iomem_ready=1 for exactly one cycle, then IDLE. Reads: iomem_rdata = RAM word at the latched index, registered on entry to ACK. Writes: iomem_rdata=0; each byte lane i with wstrb[i]=1 is written at the clock edge ending ACK. Lanes with wstrb[i]=0 are untouched.
- Latency: ready is asserted N+1 cycles after the first cycle valid is seen in IDLE, where N=WAIT_STATES. A back-to-back request costs N+2 cycles, because one IDLE cycle always follows ACK.
- Read-after-write to the same word returns the new data. The write commits before the next request can reach ACK.
- sel_o = (state != IDLE).
- Reset asserted mid-transaction: immediate return to reset values. A write pending in WAIT/ACK is dropped and the RAM keeps its old value.
- Address wrap: none. Addresses outside the window are never acknowledged; top-level default logic handles them.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2) and the WAIT_STATES width constant (4 bits).
- One sub-module: iomem_word_ram, a 2^ADDR_W x 32 array with 4 byte-write enables, one synchronous write port and an asynchronous read port. It is kept separate so it can be swapped for a RAM macro at gate level, alongside the existing RAM256/RAM512 macros.

Test Plan:
- Reset, then write 32'hDEADBEEF, wstrb=4'hF, to 32'h4000_0010 with WAIT_STATES=1 -> ready high exactly in cycle 2 after valid, rdata=0, sel_o high in cycles 1-2.
- Read 32'h4000_0010 -> ready after 2 cycles with rdata=32'hDEADBEEF; rdata=0 in every cycle where ready=0.
- Partial write wdata=32'h1122_3344, wstrb=4'b0101, to the same word, then read -> 32'hDE22BE44.
- Request to 32'h5000_0000 (miss) held for 20 cycles -> ready and sel_o stay 0 and the RAM is unchanged.
- Write to 32'h4000_0020, then assert resetn=0 during WAIT and release it; read 32'h4000_0020 -> old value returned and all outputs 0 during reset.
- WAIT_STATES=0, back-to-back reads of 32'h4000_0000 and 32'h4000_0FFC -> each ready 1 cycle after accept, 1 idle cycle between, top word indexes correctly with no wrap.
